// File: rtl/line_buf_wr.sv
// line_buf_wr: write side of the convolution line-buffer memory.
// Incoming pixels fill NM row buffers in round-robin order, one image row per
// buffer. A buffer stays full (and blocks further writes) until the control
// unit releases it with mem_used. Each buffer has its own registered read port.
module line_buf_wr #(
  parameter int XB      = 10,
  parameter int YB      = 10,
  parameter int PB      = 8,
  parameter int NM      = 4,
  parameter int MINFILL = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XB-1:0]    cfg_width,
  input  logic [YB-1:0]    cfg_height,
  input  logic             in_valid,
  input  logic [PB-1:0]    in_data,
  output logic             in_ready,
  input  logic [NM-1:0]    mem_used,
  input  logic [NM*XB-1:0] mb_rd_addr,
  output logic [NM*PB-1:0] pu_data,
  output logic [NM-1:0]    mb_full,
  output logic [NM-1:0]    mb_minfill,
  output logic             frame_in_done
);

  localparam int            BW        = (NM > 1) ? $clog2(NM) : 1;
  localparam logic [BW-1:0] LAST_BUF  = BW'(NM - 1);
  localparam logic [XB:0]   FILL_MAX  = (XB + 1)'(2 ** XB);
  localparam logic [XB:0]   MINFILL_C = (XB + 1)'(MINFILL);

  logic [BW-1:0] wr_buf_q, wr_buf_d;
  logic [XB-1:0] wr_col_q, wr_col_d;
  logic [YB-1:0] wr_row_q, wr_row_d;
  logic [XB-1:0] cfg_w_q, cfg_w_d;
  logic [YB-1:0] cfg_h_q, cfg_h_d;
  logic [NM-1:0] full_q, full_d;
  logic          done_q, done_d;

  logic          accept;
  logic          frame_start;
  logic [XB-1:0] eff_w;
  logic [YB-1:0] eff_h;
  logic          row_end;
  logic          frame_end;
  logic [NM-1:0] release_v;
  logic [NM-1:0] set_v;

  assign in_ready    = ~full_q[wr_buf_q];
  assign accept      = in_valid & in_ready;

  // The first pixel of a frame latches the geometry, and it must already be
  // judged against that new geometry (a one-pixel-wide row ends right there).
  assign frame_start = (wr_col_q == '0) && (wr_row_q == '0);
  assign eff_w       = frame_start ? cfg_width  : cfg_w_q;
  assign eff_h       = frame_start ? cfg_height : cfg_h_q;

  assign row_end     = accept && (wr_col_q == eff_w);
  assign frame_end   = row_end && (wr_row_q == eff_h);

  // A release only counts on a full buffer; the buffer being written is never
  // full, so a release and a row completion can never hit the same buffer.
  assign release_v   = mem_used & full_q;
  assign set_v       = row_end ? (NM'(1) << wr_buf_q) : '0;

  assign mb_full       = full_q;
  assign frame_in_done = done_q;

  // Next-state for the write cursor, geometry latch and full flags
  always_comb begin
    wr_buf_d = wr_buf_q;
    wr_col_d = wr_col_q;
    wr_row_d = wr_row_q;
    cfg_w_d  = cfg_w_q;
    cfg_h_d  = cfg_h_q;
    done_d   = frame_end;
    full_d   = (full_q & ~release_v) | set_v;
    if (accept) begin
      wr_col_d = wr_col_q + XB'(1);
      if (frame_start) begin
        cfg_w_d = cfg_width;
        cfg_h_d = cfg_height;
      end
      if (row_end) begin
        wr_col_d = '0;
        wr_buf_d = (wr_buf_q == LAST_BUF) ? '0 : wr_buf_q + BW'(1);
        wr_row_d = frame_end ? '0 : wr_row_q + YB'(1);
      end
    end
  end

  // Control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_buf_q <= '0;
      wr_col_q <= '0;
      wr_row_q <= '0;
      cfg_w_q  <= '0;
      cfg_h_q  <= '0;
      full_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      wr_buf_q <= wr_buf_d;
      wr_col_q <= wr_col_d;
      wr_row_q <= wr_row_d;
      cfg_w_q  <= cfg_w_d;
      cfg_h_q  <= cfg_h_d;
      full_q   <= full_d;
      done_q   <= done_d;
    end
  end

  for (genvar g = 0; g < NM; g++) begin : g_buf
    logic [PB-1:0] ram [2**XB];
    logic [XB:0]   fill_q, fill_d;
    logic [PB-1:0] rd_data_p1;
    logic          wr_sel;

    assign wr_sel = accept && (wr_buf_q == BW'(g));

    // Fill count: cleared by release, saturating count of accepted pixels
    always_comb begin
      fill_d = fill_q;
      if (release_v[g]) begin
        fill_d = '0;
      end else if (wr_sel && (fill_q != FILL_MAX)) begin
        fill_d = fill_q + (XB + 1)'(1);
      end
    end

    // Fill count register
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        fill_q <= '0;
      end else begin
        fill_q <= fill_d;
      end
    end

    // Row storage write port; contents survive reset
    always_ff @(posedge clk) begin
      if (wr_sel) begin
        ram[wr_col_q] <= in_data;
      end
    end

    // Stage p1: registered read, returns pre-write data on an address collision
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_data_p1 <= '0;
      end else begin
        rd_data_p1 <= ram[mb_rd_addr[g*XB +: XB]];
      end
    end

    assign pu_data[g*PB +: PB] = rd_data_p1;
    assign mb_minfill[g]       = full_q[g] | (fill_q >= MINFILL_C);
  end

endmodule

// File: tb/tb_line_buf_wr.sv
// Directed testbench for line_buf_wr with hand-computed expected values.
module tb_line_buf_wr;

  localparam int XB      = 10;
  localparam int YB      = 10;
  localparam int PB      = 8;
  localparam int NM      = 4;
  localparam int MINFILL = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [XB-1:0]    cfg_width;
  logic [YB-1:0]    cfg_height;
  logic             in_valid;
  logic [PB-1:0]    in_data;
  logic             in_ready;
  logic [NM-1:0]    mem_used;
  logic [NM*XB-1:0] mb_rd_addr;
  logic [NM*PB-1:0] pu_data;
  logic [NM-1:0]    mb_full;
  logic [NM-1:0]    mb_minfill;
  logic             frame_in_done;

  int n_cmp = 0;
  int n_mis = 0;

  line_buf_wr #(
    .XB(XB), .YB(YB), .PB(PB), .NM(NM), .MINFILL(MINFILL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .mem_used     (mem_used),
    .mb_rd_addr   (mb_rd_addr),
    .pu_data      (pu_data),
    .mb_full      (mb_full),
    .mb_minfill   (mb_minfill),
    .frame_in_done(frame_in_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    mem_used   = '0;
    mb_rd_addr = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic push(input logic [PB-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  task automatic set_rd(input int b, input logic [XB-1:0] a);
    mb_rd_addr[b*XB +: XB] = a;
  endtask

  function automatic logic [PB-1:0] pu(input int b);
    return pu_data[b*PB +: PB];
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    cfg_width  = 10'd3;
    cfg_height = 10'd2;

    // Reset state and first row
    do_reset();
    chk("rst_full", mb_full, 4'h0);
    chk("rst_minfill", mb_minfill, 4'h0);
    chk("rst_pu", pu_data, 32'h0);
    chk("rst_done", frame_in_done, 1'b0);
    chk("rst_ready", in_ready, 1'b1);

    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      in_data = 8'h10 + 8'(k);
      step();
      if (k == 0) chk("s1_minfill_1px", mb_minfill, 4'b0000);
      if (k == 1) chk("s1_minfill_2px", mb_minfill, 4'b0001);
      if (k == 2) chk("s1_full_3px", mb_full, 4'b0000);
    end
    in_valid = 1'b0;
    chk("s1_full_row", mb_full, 4'b0001);
    chk("s1_minfill_row", mb_minfill, 4'b0001);
    chk("s1_ready_row", in_ready, 1'b1);
    push(8'h20);
    set_rd(1, 10'd0);
    step();
    chk("s1_buf1_addr0", pu(1), 8'h20);
    chk("s1_full_after", mb_full, 4'b0001);

    // Registered read of buffer 0
    set_rd(0, 10'd2);
    step();
    chk("s3_rd_b0_a2", pu(0), 8'h12);
    set_rd(0, 10'd0);
    step();
    chk("s3_rd_b0_a0", pu(0), 8'h10);

    // All buffers full, back-pressure, release
    do_reset();
    cfg_width  = 10'd3;
    cfg_height = 10'd7;
    in_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      in_data = 8'h40 + 8'(k);
      step();
    end
    in_data = 8'h50;
    chk("s2_full_all", mb_full, 4'hF);
    chk("s2_ready_low", in_ready, 1'b0);
    set_rd(0, 10'd0);
    set_rd(3, 10'd3);
    step();
    step();
    chk("s2_full_held", mb_full, 4'hF);
    chk("s2_ready_held", in_ready, 1'b0);
    chk("s2_b0_a0_orig", pu(0), 8'h40);
    chk("s2_b3_a3", pu(3), 8'h4F);
    mem_used = 4'b0001;
    step();
    mem_used = 4'b0000;
    chk("s2_full_rel", mb_full, 4'hE);
    chk("s2_ready_rel", in_ready, 1'b1);
    chk("s2_minfill_rel", mb_minfill, 4'hE);
    step();
    in_valid = 1'b0;
    chk("s2_rd_old_on_wr", pu(0), 8'h40);
    chk("s2_full_after_wr", mb_full, 4'hE);
    chk("s2_minfill_after_wr", mb_minfill, 4'hE);
    step();
    chk("s2_rd_new", pu(0), 8'h50);

    // Whole frame, frame_in_done pulse, round-robin continues
    do_reset();
    cfg_width  = 10'd3;
    cfg_height = 10'd2;
    in_valid = 1'b1;
    for (int k = 0; k < 12; k++) begin
      in_data = 8'h60 + 8'(k);
      step();
      chk($sformatf("s4_done_px%0d", k + 1), frame_in_done, (k == 11) ? 1'b1 : 1'b0);
    end
    in_valid = 1'b0;
    step();
    chk("s4_done_clear", frame_in_done, 1'b0);
    chk("s4_full_3rows", mb_full, 4'b0111);
    chk("s4_ready_buf3", in_ready, 1'b1);
    push(8'h77);
    set_rd(3, 10'd0);
    step();
    chk("s4_next_frame_buf3", pu(3), 8'h77);
    chk("s4_full_unchanged", mb_full, 4'b0111);

    // Mid-frame config change is ignored until the next frame
    do_reset();
    cfg_width  = 10'd3;
    cfg_height = 10'd2;
    push(8'h01);
    push(8'h02);
    cfg_width = 10'd5;
    push(8'h03);
    push(8'h04);
    chk("s5_row_old_width", mb_full, 4'b0001);
    for (int k = 0; k < 8; k++) push(8'h05 + 8'(k));
    chk("s5_frame_done", frame_in_done, 1'b1);
    chk("s5_full_frame", mb_full, 4'b0111);
    for (int k = 0; k < 4; k++) push(8'h20 + 8'(k));
    chk("s5_new_width_4px", mb_full, 4'b0111);
    push(8'h24);
    push(8'h25);
    chk("s5_new_width_6px", mb_full, 4'b1111);

    // Release of an empty buffer, then asynchronous reset mid-row
    do_reset();
    cfg_width  = 10'd3;
    cfg_height = 10'd2;
    for (int k = 0; k < 4; k++) push(8'h30 + 8'(k));
    chk("s6_full_b0", mb_full, 4'b0001);
    mem_used = 4'b0100;
    step();
    mem_used = 4'b0000;
    chk("s6_rel_empty_full", mb_full, 4'b0001);
    chk("s6_rel_empty_minfill", mb_minfill, 4'b0001);
    push(8'h34);
    push(8'h35);
    chk("s6_minfill_b1", mb_minfill, 4'b0011);
    set_rd(0, 10'd1);
    step();
    chk("s6_rd_b0_a1", pu(0), 8'h31);
    #2;
    rst = 1'b1;
    #1;
    chk("s6_arst_full", mb_full, 4'h0);
    chk("s6_arst_minfill", mb_minfill, 4'h0);
    chk("s6_arst_pu", pu_data, 32'h0);
    chk("s6_arst_done", frame_in_done, 1'b0);
    chk("s6_arst_ready", in_ready, 1'b1);
    step();
    rst = 1'b0;
    push(8'hAA);
    set_rd(0, 10'd0);
    step();
    chk("s6_restart_b0", pu(0), 8'hAA);
    chk("s6_restart_full", mb_full, 4'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
